// File: rtl/commit_monitor_pkg.sv
// Shared widths, trap encoding and commit-entry layout for commit_monitor.
// Entry is one packed vector, LSB first: wdata | wdest | wen | inst | pc.
package commit_monitor_pkg;

    localparam int ADDR_BUS = 64;
    localparam int INST_BUS = 32;
    localparam int DATA_BUS = 64;
    localparam int WDEST_W  = 5;

    localparam logic [31:0] TRAP_INST_ENC = 32'h0000_006b;

    localparam int OFF_WDATA = 0;

    function automatic int off_wdest(int data_w);
        return data_w;
    endfunction

    function automatic int off_wen(int data_w);
        return data_w + WDEST_W;
    endfunction

    function automatic int off_inst(int data_w);
        return data_w + WDEST_W + 1;
    endfunction

    function automatic int off_pc(int inst_w, int data_w);
        return data_w + WDEST_W + 1 + inst_w;
    endfunction

    function automatic int entry_w(int addr_w, int inst_w, int data_w);
        return off_pc(inst_w, data_w) + addr_w;
    endfunction

endpackage

// File: rtl/commit_monitor_if.sv
// Retire-side inputs and drain-side handshake of commit_monitor.
// The monitor uses the slave modport; the producer/consumer side uses master.
interface commit_monitor_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 64,
    parameter int INST_W = 32,
    parameter int DATA_W = 64
);
    logic [NCH-1:0]        in_valid;
    logic [NCH*ADDR_W-1:0] in_pc;
    logic [NCH*INST_W-1:0] in_inst;
    logic [NCH-1:0]        in_wen;
    logic [NCH*5-1:0]      in_wdest;
    logic [NCH*DATA_W-1:0] in_wdata;
    logic                  out_ready;
    logic                  out_valid;
    logic [ADDR_W-1:0]     out_pc;
    logic [INST_W-1:0]     out_inst;
    logic                  out_wen;
    logic [7:0]            out_wdest;
    logic [DATA_W-1:0]     out_wdata;
    logic [7:0]            out_seq;

    modport master (
        output in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, out_ready,
        input  out_valid, out_pc, out_inst, out_wen, out_wdest, out_wdata, out_seq
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, out_ready,
        output out_valid, out_pc, out_inst, out_wen, out_wdest, out_wdata, out_seq
    );
endinterface

// File: rtl/commit_fifo.sv
// In-order circular buffer: up to NCH compacted writes and one read per cycle.
// free_cnt already counts the slot released by a read in the same cycle.
module commit_fifo #(
    parameter int  NCH   = 2,
    parameter int  DEPTH = 8,
    parameter int  W     = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int FW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NCH-1:0]   wr_mask,
    input  logic [NCH*W-1:0] wr_data,
    input  logic             rd_en,
    output logic [W-1:0]     rd_data,
    output logic             empty,
    output logic [FW-1:0]    free_cnt
);
    logic [FW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] slot [NCH];
    logic [AW-1:0] idx_diff;
    logic [FW-1:0] used;
    logic          full;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        idx_diff = wr_ptr_q[AW-1:0] - rd_ptr_q[AW-1:0];
        used     = full ? FW'(DEPTH) : {1'b0, idx_diff};
        free_cnt = FW'(DEPTH) - used + FW'(rd_en);
        rd_data  = mem_q[rd_ptr_q[AW-1:0]];
        rd_ptr_d = rd_ptr_q + FW'(rd_en);
        // NOTE: blocking updates here chain each selected channel onto the next free slot within one evaluation.
        wr_ptr_d = wr_ptr_q;
        for (int i = 0; i < NCH; i++) begin
            slot[i] = wr_ptr_d[AW-1:0];
            if (wr_mask[i]) wr_ptr_d = wr_ptr_d + FW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NCH; i++) begin
            if (wr_mask[i]) mem_q[slot[i]] <= wr_data[i*W +: W];
        end
    end

endmodule

// File: rtl/commit_monitor.sv
// Retirement monitor: qualifies per-channel commits, buffers them in order, drains one per cycle.
// Optional perf counters are built when COMMIT_MON_PERF_EN is defined.
module commit_monitor
    import commit_monitor_pkg::*;
#(
    parameter int ADDR_W = ADDR_BUS,
    parameter int INST_W = INST_BUS,
    parameter int DATA_W = DATA_BUS,
    parameter int NCH    = 2,
    parameter int DEPTH  = 8,
    parameter logic [INST_W-1:0] TRAP_INST = INST_W'(TRAP_INST_ENC)
) (
    input  logic              clock,
    input  logic              reset,
    commit_monitor_if.slave   bus,
    output logic              overflow,
    output logic              trap_hit,
    output logic [ADDR_W-1:0] trap_pc,
    output logic [63:0]       perf_cycles,
    output logic [63:0]       perf_instret
);
    localparam int EW       = entry_w(ADDR_W, INST_W, DATA_W);
    localparam int FW       = $clog2(DEPTH) + 1;
    localparam int O_WDEST  = off_wdest(DATA_W);
    localparam int O_WEN    = off_wen(DATA_W);
    localparam int O_INST   = off_inst(DATA_W);
    localparam int O_PC     = off_pc(INST_W, DATA_W);

    logic [ADDR_W-1:0] ch_pc [NCH];
    logic [NCH-1:0]    qual, fifo_wr;
    logic [NCH*EW-1:0] wr_data;
    logic [EW-1:0]     fifo_rd, head;
    logic [FW-1:0]     q_cnt, free_cnt;
    logic              empty, drop, deq;

    logic [ADDR_W-1:0] last_pc_q, last_pc_d, trap_pc_q, trap_pc_d;
    logic [7:0]        seq_q, seq_d;
    logic              overflow_q, overflow_d, trap_hit_q, trap_hit_d;

    // Channels are checked only against last_pc, never against each other.
    always_comb begin
        q_cnt     = '0;
        wr_data   = '0;
        last_pc_d = last_pc_q;
        for (int i = 0; i < NCH; i++) begin
            ch_pc[i] = bus.in_pc[i*ADDR_W +: ADDR_W];
            qual[i]  = bus.in_valid[i] && (bus.in_inst[i*INST_W +: INST_W] != '0)
                       && (ch_pc[i] != last_pc_q);
            q_cnt    = q_cnt + FW'(qual[i]);
            wr_data[i*EW +: EW] = {ch_pc[i], bus.in_inst[i*INST_W +: INST_W], bus.in_wen[i],
                                   bus.in_wdest[i*WDEST_W +: WDEST_W], bus.in_wdata[i*DATA_W +: DATA_W]};
        end
        drop       = (q_cnt > free_cnt);
        fifo_wr    = qual & {NCH{~drop}};
        overflow_d = overflow_q | drop;
        for (int i = 0; i < NCH; i++) begin
            if (fifo_wr[i]) last_pc_d = ch_pc[i];
        end
    end

    commit_fifo #(.NCH(NCH), .DEPTH(DEPTH), .W(EW)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .wr_mask  (fifo_wr),
        .wr_data  (wr_data),
        .rd_en    (deq),
        .rd_data  (fifo_rd),
        .empty    (empty),
        .free_cnt (free_cnt)
    );

    always_comb begin
        head          = fifo_rd & {EW{~empty}};
        deq           = ~empty & bus.out_ready;
        bus.out_valid = ~empty;
        bus.out_pc    = head[O_PC +: ADDR_W];
        bus.out_inst  = head[O_INST +: INST_W];
        bus.out_wen   = head[O_WEN] && (head[O_WDEST +: WDEST_W] != '0);
        bus.out_wdest = 8'(head[O_WDEST +: WDEST_W]);
        bus.out_wdata = head[OFF_WDATA +: DATA_W];
        bus.out_seq   = seq_q;
        seq_d         = seq_q + 8'(deq);
        trap_hit_d    = trap_hit_q;
        trap_pc_d     = trap_pc_q;
        if (deq && !trap_hit_q && (bus.out_inst == TRAP_INST)) begin
            trap_hit_d = 1'b1;
            trap_pc_d  = bus.out_pc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_pc_q  <= '1;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            trap_hit_q <= 1'b0;
            trap_pc_q  <= '0;
        end else begin
            last_pc_q  <= last_pc_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            trap_hit_q <= trap_hit_d;
            trap_pc_q  <= trap_pc_d;
        end
    end

    assign overflow = overflow_q;
    assign trap_hit = trap_hit_q;
    assign trap_pc  = trap_pc_q;

`ifdef COMMIT_MON_PERF_EN
    logic [63:0] cycles_q, cycles_d, instret_q, instret_d;

    always_comb begin
        cycles_d  = cycles_q + 64'd1;
        instret_d = instret_q + 64'(deq);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycles_q  <= '0;
            instret_q <= '0;
        end else begin
            cycles_q  <= cycles_d;
            instret_q <= instret_d;
        end
    end

    assign perf_cycles  = cycles_q;
    assign perf_instret = instret_q;
`else
    assign perf_cycles  = '0;
    assign perf_instret = '0;
`endif

endmodule
